// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS32 decode stage with built-in ID/EX register, operand forwarding and load-use stall.
// Optional: define ID_BRANCH_EN to decode BEQ/BNE with the compare resolved in this stage.
`ifndef ALU_NOP
`define ALU_NOP  5'd0
`define ALU_OR   5'd1
`define ALU_MOV  5'd2
`define ALU_MULT 5'd3
`define ALU_DIV  5'd4
`endif

module id_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int NUM_BYP = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               inst_i,
    input  logic [31:0]               pc_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [4:0]                readAddr1_o,
    output logic [4:0]                readAddr2_o,
    output logic                      readEnable1_o,
    output logic                      readEnable2_o,
    input  logic [DATA_W-1:0]         readData1_i,
    input  logic [DATA_W-1:0]         readData2_i,
    input  logic [DATA_W-1:0]         HI_data_i,
    input  logic [DATA_W-1:0]         LO_data_i,
    input  logic [NUM_BYP-1:0]        byp_writeEnable_i,
    input  logic [5*NUM_BYP-1:0]      byp_writeAddr_i,
    input  logic [DATA_W*NUM_BYP-1:0] byp_writeData_i,
    input  logic [2*NUM_BYP-1:0]      byp_writeHILO_i,
    input  logic [DATA_W*NUM_BYP-1:0] byp_writeHI_data_i,
    input  logic [NUM_BYP-1:0]        byp_isLoad_i,
    input  logic                      ex_ready_i,
    input  logic                      flush_i,
    output logic                      branchEnable_o,
    output logic [31:0]               branchAddr_o,
    output logic                      valid_o,
    output logic [DATA_W-1:0]         oprand1_o,
    output logic [DATA_W-1:0]         oprand2_o,
    output logic [4:0]                writeAddr_o,
    output logic                      writeEnable_o,
    output logic [1:0]                writeHILO_o,
    output logic [4:0]                ALUop_o,
    output logic                      signed_o
);
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic is_special, is_ori, is_j, is_mfhi, is_mthi, is_mult, is_div, is_beq, is_bne;
    logic re1, re2, haz, hazard, fire, taken;
    logic [DATA_W-1:0] fwd1, fwd2, fwd_hi, lo_arch, op1, op2;
    logic [4:0] wa, alu;
    logic we, sg;
    logic [1:0] hilo;
    logic [31:0] target;

    assign op     = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign rd     = inst_i[15:11];
    assign funct  = inst_i[5:0];
    assign imm    = inst_i[15:0];
    assign lo_arch = LO_data_i;

    assign is_special = op == 6'b000000;
    assign is_ori     = op == 6'b001101;
    assign is_j       = op == 6'b000010;
    assign is_mfhi    = is_special && funct == 6'b010000;
    assign is_mthi    = is_special && funct == 6'b010001;
    assign is_mult    = is_special && funct == 6'b011000;
    assign is_div     = is_special && funct == 6'b011010;
`ifdef ID_BRANCH_EN
    assign is_beq     = op == 6'b000100;
    assign is_bne     = op == 6'b000101;
`else
    assign is_beq     = 1'b0;
    assign is_bne     = 1'b0;
`endif

    assign re1           = is_ori | is_mthi | is_mult | is_div | is_beq | is_bne;
    assign re2           = is_mult | is_div | is_beq | is_bne;
    assign readEnable1_o = re1;
    assign readEnable2_o = re2;
    assign readAddr1_o   = re1 ? rs : 5'd0;
    assign readAddr2_o   = re2 ? rt : 5'd0;

    // Forwarding: walk channels oldest to youngest so channel 0 overrides; also flag load-use matches
    always_comb begin
        fwd1   = readData1_i;
        fwd2   = readData2_i;
        fwd_hi = HI_data_i;
        haz    = 1'b0;
        for (int k = NUM_BYP - 1; k >= 0; k--) begin
            if (byp_writeEnable_i[k] && byp_writeAddr_i[5*k +: 5] == rs)
                fwd1 = byp_writeData_i[DATA_W*k +: DATA_W];
            if (byp_writeEnable_i[k] && byp_writeAddr_i[5*k +: 5] == rt)
                fwd2 = byp_writeData_i[DATA_W*k +: DATA_W];
            if (byp_writeHILO_i[2*k+1])
                fwd_hi = byp_writeHI_data_i[DATA_W*k +: DATA_W];
            if (byp_writeEnable_i[k] && byp_isLoad_i[k] &&
                ((re1 && rs != 5'd0 && byp_writeAddr_i[5*k +: 5] == rs) ||
                 (re2 && rt != 5'd0 && byp_writeAddr_i[5*k +: 5] == rt)))
                haz = 1'b1;
        end
        if (rs == 5'd0)
            fwd1 = '0;
        if (rt == 5'd0)
            fwd2 = '0;
    end

    assign op1  = re1 ? fwd1 : (is_mfhi ? fwd_hi : '0);
    assign op2  = re2 ? fwd2 : (is_ori ? {{(DATA_W-16){1'b0}}, imm} : '0);
    assign wa   = is_ori ? rt : (is_mfhi ? rd : 5'd0);
    assign we   = is_ori | is_mfhi;
    assign hilo = is_mthi ? 2'b10 : ((is_mult | is_div) ? 2'b11 : 2'b00);
    assign alu  = is_ori ? `ALU_OR : (is_mfhi | is_mthi) ? `ALU_MOV :
                  is_mult ? `ALU_MULT : is_div ? `ALU_DIV : `ALU_NOP;
    assign sg   = is_div;

    assign hazard  = valid_i && haz;
    assign ready_o = rst && !hazard && (!valid_o || ex_ready_i);
    assign fire    = valid_i && ready_o;

`ifdef ID_BRANCH_EN
    assign taken  = is_j | (is_beq & (op1 == op2)) | (is_bne & (op1 != op2));
    assign target = is_j ? {pc_i[31:28], inst_i[25:0], 2'b00}
                         : pc_i + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
`else
    assign taken  = is_j;
    assign target = {pc_i[31:28], inst_i[25:0], 2'b00};
`endif

    assign branchEnable_o = fire && taken && !flush_i;
    assign branchAddr_o   = branchEnable_o ? target : 32'd0;

    // ID/EX register: flush beats a new fire, which beats EX draining the held instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o       <= 1'b0;
            oprand1_o     <= '0;
            oprand2_o     <= '0;
            writeAddr_o   <= 5'd0;
            writeEnable_o <= 1'b0;
            writeHILO_o   <= 2'b00;
            ALUop_o       <= `ALU_NOP;
            signed_o      <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (fire) begin
            valid_o       <= 1'b1;
            oprand1_o     <= op1;
            oprand2_o     <= op2;
            writeAddr_o   <= wa;
            writeEnable_o <= we;
            writeHILO_o   <= hilo;
            ALUop_o       <= alu;
            signed_o      <= sg;
        end else if (valid_o && ex_ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised MIPS32 decode stage with an ID/EX pipeline register built in. Decodes ORI, J, MFHI, MTHI, MULT, DIV and selects operands from the register file, HI/LO, immediate or any of NUM_BYP bypass channels. Adds load-use stall detection, a valid/ready handshake toward EX, and flush. Sits between the IF/ID register and EX.

Parameters:
DATA_W, 32, datapath width of operands, bypass data and HI/LO.
NUM_BYP, 2, number of bypass channels; channel 0 is youngest (EX) and has the highest priority.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
inst_i  in  32  instruction
pc_i  in  32  PC of inst_i
valid_i  in  1  inst_i valid
ready_o  out  1  stage can accept inst_i this cycle
readAddr1_o / readAddr2_o  out  5  register-file read addresses (combinational)
readEnable1_o / readEnable2_o  out  1  register-file read enables (combinational)
readData1_i / readData2_i  in  DATA_W  register-file read data
HI_data_i / LO_data_i  in  DATA_W  architectural HI/LO
byp_writeEnable_i  in  NUM_BYP  per-channel GPR write enable
byp_writeAddr_i  in  5*NUM_BYP  per-channel destination address, channel k at [5k+4:5k]
byp_writeData_i  in  DATA_W*NUM_BYP  per-channel GPR/LO result
byp_writeHILO_i  in  2*NUM_BYP  per-channel {HI,LO} write mask
byp_writeHI_data_i  in  DATA_W*NUM_BYP  per-channel HI result
byp_isLoad_i  in  NUM_BYP  channel holds a load; result not yet valid
ex_ready_i  in  1  EX accepts the registered instruction
flush_i  in  1  kill the registered and incoming instruction
branchEnable_o  out  1  redirect IF (combinational)
branchAddr_o  out  32  redirect target (combinational)
valid_o  out  1  registered instruction valid
oprand1_o / oprand2_o  out  DATA_W  registered operands
writeAddr_o  out  5  registered destination address
writeEnable_o  out  1  registered GPR write enable
writeHILO_o  out  2  registered HI/LO write mask
ALUop_o  out  5  registered ALU operation, `ALU_* encoding
signed_o  out  1  registered signed flag

Behaviour:
- Decode per MIPS32:
  - ORI: rs, zero-extended imm -> rt, `ALU_OR.
  - J: branchEnable_o=1, target {pc_i[31:28],inst_i[25:0],2'b0}.
  - MFHI: HI -> rd, `ALU_MOV.
  - MTHI: rs -> operand1, writeHILO=10, `ALU_MOV.
  - MULT: rs, rt, writeHILO=11, `ALU_MULT.
  - DIV: as MULT plus signed=1, `ALU_DIV.
  - Anything else: `ALU_NOP, no writes.
- Operand select, first match wins:
  - HI/LO read: lowest-index channel whose matching mask bit is set, else architectural HI/LO.
  - GPR read, addr!=0: lowest-index channel k with writeEnable[k] and addr match, else readData.
  - Read addr 0 always yields 0, never forwarded.
  - Read not enabled: immediate (operand2) or 0.
- hazard = valid_i and some enabled read (addr!=0) matches channel k with writeEnable[k] & isLoad[k].
- ready_o = !hazard && (!valid_o || ex_ready_i); forced 0 while rst low.
- fire = valid_i && ready_o. branchEnable_o = fire && J && !flush_i; branchAddr_o is 0 when branchEnable_o=0.
- Register update, in priority order:
  - flush_i: valid_o<=0.
  - fire: load decoded fields, valid_o<=1.
  - valid_o && ex_ready_i: valid_o<=0.
  - Otherwise hold all fields.
- A stalled instruction is re-decoded every cycle, so forwarded values refresh until fire. Latency is 1 cycle from fire to valid_o.
- Reset: all registered outputs 0, ALUop_o=`ALU_NOP. Asserting reset mid-stall discards the instruction.
- Fields while valid_o=0 are don't-care to EX but must be stable.

Optional Feature:
ID_BRANCH_EN defined: BEQ (op 000100) and BNE (op 000101) are decoded.
- Both read rs and rt with forwarding; no register write.
- Compare happens in ID; taken -> branchEnable_o=fire, target pc_i+4+{signext(imm),2'b0}.
- Load-use hazard checked as above.
Undefined: BEQ and BNE decode as NOP.

Test Plan:
1. ORI r2,r1,0x00FF with r1=0x1200 from register file, ex_ready_i=1 -> next cycle valid_o=1, oprand1_o=0x1200, oprand2_o=0x00FF, writeAddr_o=2, ALUop_o=`ALU_OR.
2. ORI reading r3; ch0 writes r3=0xA, ch1 writes r3=0xB -> oprand1_o=0xA. Repeat reading r0 with ch0 addr=0 -> oprand1_o=0.
3. MULT r4,r5 with ch0 isLoad and writeAddr=5 -> ready_o=0 for 1 cycle, valid_o=0 during it; next cycle isLoad=0, data=7 -> oprand2_o=7.
4. valid_o=1 and ex_ready_i=0 for 3 cycles with a new instruction presented -> outputs held, ready_o=0, no extra fire.
5. MFHI r8 with ch1 mask=10 and HI=0x55, HI_data_i=0x11 -> oprand1_o=0x55. J at pc 0x80001000 with index 0x40 -> branchAddr_o=0x80000100.
6. flush_i together with a firing J -> branchEnable_o=0, valid_o=0. Then rst low mid-stall -> all outputs 0 immediately.
